// File: rtl/clock_set_sequencer.sv
// Time/alarm entry sequencer and 1 Hz tick generator for the digital clock.
// Optional abort on idle set states: define SET_TIMEOUT_EN.
module clock_set_sequencer #(
    parameter int CLK_DIV        = 100000000,
    parameter int TIMEOUT_CYCLES = 1000000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       alarm_set,
    input  logic [5:0] input_data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic [5:0] load_data,
    output logic       ld_hr,
    output logic       ld_min,
    output logic       ld_sec,
    output logic       ld_alarm_hr,
    output logic       ld_alarm_min,
    output logic       ld_alarm_sec,
    output logic       on,
    output logic       sec_tick,
    output logic       range_err,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        SET_SEC = 3'd3,
        RUN     = 3'd4,
        ALM_HR  = 3'd5,
        ALM_MIN = 3'd6,
        ALM_SEC = 3'd7
    } state_t;

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] P_MAX = PW'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_div_chk
        $error("CLK_DIV must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_to_chk
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t        state_q, state_d, adv;
    logic [5:0]    load_q, load_d;
    logic [5:0]    ld_q, ld_d, sel;
    logic          err_q, err_d;
    logic [PW-1:0] pcnt_q;
    logic          accept, in_range, abort;

    assign data_ready = (state_q != IDLE) && (state_q != RUN);
    assign on         = state_q[2];
    assign sec_tick   = on && (pcnt_q == P_MAX);
    assign state_o    = state_q;
    assign load_data  = load_q;
    assign range_err  = err_q;
    assign accept     = data_valid && data_ready;
    assign in_range   = (state_q == SET_HR || state_q == ALM_HR) ?
                        (input_data <= 6'd23) : (input_data <= 6'd59);

    assign {ld_alarm_sec, ld_alarm_min, ld_alarm_hr,
            ld_sec, ld_min, ld_hr} = ld_q;

`ifdef SET_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tcnt_q;

    assign abort = data_ready && (tcnt_q == T_MAX);

    // Idle-time counter, restarted on every state entry and every accepted entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tcnt_q <= '0;
        else if (!data_ready || accept || state_d != state_q)
            tcnt_q <= '0;
        else
            tcnt_q <= tcnt_q + TW'(1);
    end
`else
    assign abort = 1'b0;
`endif

    // Per-state strobe select and the state reached on a good entry.
    always_comb begin
        sel = '0;
        adv = state_q;
        unique case (state_q)
            SET_HR:  begin sel = 6'b000001; adv = SET_MIN; end
            SET_MIN: begin sel = 6'b000010; adv = SET_SEC; end
            SET_SEC: begin sel = 6'b000100; adv = RUN;     end
            ALM_HR:  begin sel = 6'b001000; adv = ALM_MIN; end
            ALM_MIN: begin sel = 6'b010000; adv = ALM_SEC; end
            ALM_SEC: begin sel = 6'b100000; adv = RUN;     end
            default: ;
        endcase
    end

    // Next state, next load value, strobes and reject flag.
    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        ld_d    = '0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start)
                    state_d = SET_HR;
            end
            RUN: begin
                if (start)
                    state_d = SET_HR;
                else if (alarm_set)
                    state_d = ALM_HR;
            end
            default: begin
                if (abort) begin
                    state_d = state_q[2] ? RUN : IDLE;
                    err_d   = 1'b1;
                end else if (accept) begin
                    if (in_range) begin
                        load_d  = input_data;
                        ld_d    = sel;
                        state_d = adv;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // State and registered datapath outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            load_q  <= '0;
            ld_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
        end
    end

    // Seconds prescaler: free-runs while the clock is on, parked at 0 otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pcnt_q <= '0;
        else if (!on || pcnt_q == P_MAX)
            pcnt_q <= '0;
        else
            pcnt_q <= pcnt_q + PW'(1);
    end

endmodule
